id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The parameters SHALL be, one per line: name, default, meaning.
- FLUSH_CYCLES, 1, fetch slots squashed per redirect, legal range 1..4.
REQ-002 The ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- instIn  in  16  instruction from fetch, valid every cycle.
- pcIn  in  16  fetch PC of instIn.
- pcNIn  in  16  fetch PC+2 of instIn.
- zeroFlag  in  1  condition for conditional branch, sampled on the fire cycle.
- idReady  in  1  downstream accepts idInst this cycle.
- pcEn  out  1  fetch PC register enable.
- branchSel  out  1  fetch selects branchVal as next PC.
- branchVal  out  8  absolute branch target, zero-extended by fetch.
- idValid  out  1  idInst/idPc/idPcN hold a live instruction.
- idInst  out  16  latched instruction.
- idPc  out  16  latched PC.
- idPcN  out  16  latched PC+2.

Function
REQ-003 The FSM SHALL have exactly two states: RUN and FLUSH.
REQ-004 Decode on idInst: opcode = idInst[15:12]; JMP = 4'hC (always taken); BEQZ = 4'hD (taken when zeroFlag=1); target = idInst[7:0].
REQ-005 stall = idValid & ~idReady; fire = idValid & idReady & taken-branch.
REQ-006 In RUN with stall=1: pcEn=0, branchSel=0, all id* registers hold.
REQ-007 In RUN with stall=0 and fire=0: pcEn=1; next edge latches instIn/pcIn/pcNIn into idInst/idPc/idPcN and sets idValid=1.
REQ-008 In RUN with fire=1 (same cycle): branchSel=1, branchVal=target, pcEn=1, instIn squashed, next idValid=0.
REQ-009 After fire, FSM SHALL enter FLUSH when FLUSH_CYCLES>1, else stay in RUN.
REQ-010 In FLUSH: pcEn=1, branchSel=0, idValid=0, instIn discarded.
REQ-011 FLUSH SHALL stay for FLUSH_CYCLES-1 cycles using a 2-bit down-counter, then return to RUN.
REQ-012 branchSel SHALL be 0 in every cycle other than a fire cycle; branchVal SHALL be 8'h00 when branchSel=0.
REQ-013 Latency: an instruction presented on instIn in an accepting cycle appears on idInst on the next cycle.
REQ-014 A branch held under stall SHALL NOT fire until idReady=1; zeroFlag is sampled only on the fire cycle.
REQ-015 Back-to-back branches: the second branch is squashed by the first and never fires.

Reset
REQ-016 While rst=1: pcEn=0, branchSel=0, branchVal=8'h00.
REQ-017 At the edge with rst=1: idValid=0, idInst=16'h0000, idPc=16'h0000, idPcN=16'h0000, state=RUN, counter=0.
REQ-018 rst asserted during FLUSH or stall SHALL abort the operation; the first cycle after reset is RUN with pcEn=1.

Configuration
REQ-019 Macro ID_COND_BRANCH_EN: when defined, BEQZ behaves per REQ-004.
REQ-020 When ID_COND_BRANCH_EN is undefined, opcode 4'hD SHALL be an ordinary non-branch instruction, zeroFlag SHALL be ignored, and JMP SHALL be unaffected.

Structure
REQ-021 Shared package octa16_pkg SHALL hold the OP_JMP/OP_BEQZ opcode constants and the id_state_t enum {RUN, FLUSH}.
REQ-022 Branch decode (opcode, zeroFlag -> taken, target) SHALL be the combinational sub-module branch_decode.

Verification
REQ-023 Streaming: pcIn 0x0000,0x0002,0x0004, idReady=1 -> idPc 0x0000,0x0002,0x0004 one cycle later each; pcEn=1 throughout.
REQ-024 Stall: idReady=0 for 3 cycles with idValid=1 -> pcEn=0 and idInst held for 3 cycles; release -> next instruction latched.
REQ-025 JMP: idInst=16'hC040, idReady=1 -> one cycle with branchSel=1 and branchVal=8'h40; next cycle idValid=0; following cycle idPc=16'h0040.
REQ-026 BEQZ: idInst=16'hD020 with zeroFlag=0 -> no redirect. With zeroFlag=1 -> branchVal=8'h20. With the macro undefined -> no redirect.
REQ-027 FLUSH_CYCLES=3: JMP fire -> idValid=0 for 3 cycles, then target captured. rst pulsed in the second flush cycle -> RUN, idValid=0, pcEn=1 after reset.

Source files
------------

// File: rtl/octa16_pkg.sv
// Shared octa16 decode constants and the ID-stage state type.
// Imported by the decode sub-module and the ID stage.
package octa16_pkg;

    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_BEQZ = 4'hD;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } id_state_t;

endpackage

// File: rtl/branch_decode.sv
// Combinational branch decode: opcode and zero flag to taken/target.
// Optional macro ID_COND_BRANCH_EN enables BEQZ as a conditional branch.
module branch_decode
    import octa16_pkg::*;
(
    input  logic [15:0] inst_i,
    input  logic        zero_flag_i,
    output logic        taken_o,
    output logic [7:0]  target_o
);

    logic [3:0] opcode;
    logic       unused_bits;

    assign opcode   = inst_i[15:12];
    assign target_o = inst_i[7:0];

`ifdef ID_COND_BRANCH_EN
    assign unused_bits = ^inst_i[11:8];

    always_comb begin
        taken_o = 1'b0;
        if (opcode == OP_JMP) begin
            taken_o = 1'b1;
        end else if (opcode == OP_BEQZ) begin
            taken_o = zero_flag_i;
        end
    end
`else
    // Without conditional branches the zero flag has no consumer.
    assign unused_bits = ^{inst_i[11:8], zero_flag_i};

    always_comb begin
        taken_o = (opcode == OP_JMP);
    end
`endif

endmodule

// File: rtl/id_stage.sv
// Instruction-decode latch with same-cycle branch redirect and fetch-slot squash.
// Optional macro ID_COND_BRANCH_EN (via branch_decode) makes BEQZ a conditional branch.
module id_stage
    import octa16_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instIn,
    input  logic [15:0] pcIn,
    input  logic [15:0] pcNIn,
    input  logic        zeroFlag,
    input  logic        idReady,
    output logic        pcEn,
    output logic        branchSel,
    output logic [7:0]  branchVal,
    output logic        idValid,
    output logic [15:0] idInst,
    output logic [15:0] idPc,
    output logic [15:0] idPcN
);

    // Counter value loaded on a fire so FLUSH lasts FLUSH_CYCLES-1 cycles.
    localparam logic [1:0] FLUSH_LOAD = 2'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

    id_state_t   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pcn_q, pcn_d;

    logic        taken;
    logic [7:0]  target;
    logic        stall;
    logic        fire;

    branch_decode u_branch_decode (
        .inst_i      (inst_q),
        .zero_flag_i (zeroFlag),
        .taken_o     (taken),
        .target_o    (target)
    );

    assign stall = valid_q & ~idReady;
    assign fire  = valid_q & idReady & taken;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        pc_d      = pc_q;
        pcn_d     = pcn_q;
        pcEn      = 1'b0;
        branchSel = 1'b0;
        branchVal = 8'h00;

        case (state_q)
            RUN: begin
                if (stall) begin
                    pcEn = 1'b0;
                end else if (fire) begin
                    // The slot on instIn is the wrong-path fall-through; drop it.
                    pcEn      = 1'b1;
                    branchSel = 1'b1;
                    branchVal = target;
                    valid_d   = 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end else begin
                    pcEn    = 1'b1;
                    valid_d = 1'b1;
                    inst_d  = instIn;
                    pc_d    = pcIn;
                    pcn_d   = pcNIn;
                end
            end
            FLUSH: begin
                pcEn    = 1'b1;
                valid_d = 1'b0;
                if (cnt_q == 2'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = RUN;
                valid_d = 1'b0;
            end
        endcase

        if (rst) begin
            pcEn      = 1'b0;
            branchSel = 1'b0;
            branchVal = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            inst_q  <= 16'h0000;
            pc_q    <= 16'h0000;
            pcn_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            pcn_q   <= pcn_d;
        end
    end

    assign idValid = valid_q;
    assign idInst  = inst_q;
    assign idPc    = pc_q;
    assign idPcN   = pcn_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: two instances (FLUSH_CYCLES=1 and 3) share directed stimulus,
// each checked every cycle against a slot-counting model plus literal expectations.
module tb_id_stage;

`ifdef ID_COND_BRANCH_EN
    localparam bit COND = 1'b1;
`else
    localparam bit COND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instIn, pcIn, pcNIn;
    logic        zeroFlag, idReady;

    logic [1:0]        o_pcEn, o_bs, o_vld;
    logic [1:0][7:0]   o_bv;
    logic [1:0][15:0]  o_inst, o_pc, o_pcn;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    id_stage #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .instIn(instIn), .pcIn(pcIn), .pcNIn(pcNIn),
        .zeroFlag(zeroFlag), .idReady(idReady),
        .pcEn(o_pcEn[0]), .branchSel(o_bs[0]), .branchVal(o_bv[0]),
        .idValid(o_vld[0]), .idInst(o_inst[0]), .idPc(o_pc[0]), .idPcN(o_pcn[0])
    );

    id_stage #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .instIn(instIn), .pcIn(pcIn), .pcNIn(pcNIn),
        .zeroFlag(zeroFlag), .idReady(idReady),
        .pcEn(o_pcEn[1]), .branchSel(o_bs[1]), .branchVal(o_bv[1]),
        .idValid(o_vld[1]), .idInst(o_inst[1]), .idPc(o_pc[1]), .idPcN(o_pcn[1])
    );

    // Model: a latched slot plus a count of fetch slots still to be squashed.
    bit          m_v[2];
    logic [15:0] m_inst[2], m_pc[2], m_pcn[2];
    int          m_squash[2];

    function automatic int fc_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit is_taken(logic [15:0] inst, logic zf);
        return (inst[15:12] == 4'hC) || (COND && inst[15:12] == 4'hD && zf);
    endfunction

    task automatic check(string name, int k, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] t=%0t: got %h expected %h", name, fc_of(k), $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_v[k] = 1'b0; m_inst[k] = 16'h0; m_pc[k] = 16'h0; m_pcn[k] = 16'h0;
                m_squash[k] = 0;
            end else if (m_squash[k] > 0) begin
                m_squash[k] = m_squash[k] - 1;
                m_v[k] = 1'b0;
            end else if (m_v[k] && !idReady) begin
                m_v[k] = m_v[k];
            end else if (m_v[k] && is_taken(m_inst[k], zeroFlag)) begin
                m_v[k] = 1'b0;
                m_squash[k] = fc_of(k) - 1;
            end else begin
                m_v[k] = 1'b1; m_inst[k] = instIn; m_pc[k] = pcIn; m_pcn[k] = pcNIn;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic       e_en, e_bs;
                logic [7:0] e_bv;
                e_en = 1'b0; e_bs = 1'b0; e_bv = 8'h00;
                if (!rst) begin
                    if (m_squash[k] > 0) begin
                        e_en = 1'b1;
                    end else if (m_v[k] && !idReady) begin
                        e_en = 1'b0;
                    end else begin
                        e_en = 1'b1;
                        if (m_v[k] && is_taken(m_inst[k], zeroFlag)) begin
                            e_bs = 1'b1;
                            e_bv = m_inst[k][7:0];
                        end
                    end
                end
                check("pcEn", k, 16'(o_pcEn[k]), 16'(e_en));
                check("branchSel", k, 16'(o_bs[k]), 16'(e_bs));
                check("branchVal", k, 16'(o_bv[k]), 16'(e_bv));
                check("idValid", k, 16'(o_vld[k]), 16'(m_v[k]));
                if (m_v[k]) begin
                    check("idInst", k, o_inst[k], m_inst[k]);
                    check("idPc", k, o_pc[k], m_pc[k]);
                    check("idPcN", k, o_pcn[k], m_pcn[k]);
                end
            end
        end
    end

    task automatic step(input logic r, input logic [15:0] inst, input logic [15:0] pc,
                        input logic zf, input logic rdy);
        @(posedge clk);
        #1;
        rst = r; instIn = inst; pcIn = pc; pcNIn = pc + 16'd2;
        zeroFlag = zf; idReady = rdy;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; instIn = 16'h0; pcIn = 16'h0; pcNIn = 16'h2;
        zeroFlag = 1'b0; idReady = 1'b1;

        step(1, 16'h0000, 16'h0000, 0, 1);
        chk_en = 1'b1;
        step(1, 16'h0000, 16'h0000, 0, 1);
        check("rst_pcEn", 0, 16'(o_pcEn[0]), 16'h0);
        check("rst_idValid", 0, 16'(o_vld[0]), 16'h0);
        check("rst_idInst", 0, o_inst[0], 16'h0000);
        check("rst_idPc", 0, o_pc[0], 16'h0000);
        check("rst_idPcN", 0, o_pcn[0], 16'h0000);
        check("rst_idValid", 1, 16'(o_vld[1]), 16'h0);

        // Streaming
        step(0, 16'h1000, 16'h0000, 0, 1);
        check("run_pcEn", 0, 16'(o_pcEn[0]), 16'h1);
        step(0, 16'h1001, 16'h0002, 0, 1);
        check("stream_pc0", 0, o_pc[0], 16'h0000);
        check("stream_pcn0", 0, o_pcn[0], 16'h0002);
        step(0, 16'h1002, 16'h0004, 0, 1);
        check("stream_pc1", 0, o_pc[0], 16'h0002);
        step(0, 16'h1003, 16'h0006, 0, 1);
        check("stream_pc2", 0, o_pc[0], 16'h0004);

        // Stall three cycles
        for (int i = 0; i < 3; i++) begin
            step(0, 16'h1004, 16'h0008, 0, 0);
            check("stall_pcEn", 0, 16'(o_pcEn[0]), 16'h0);
            check("stall_hold", 0, o_inst[0], 16'h1003);
        end
        step(0, 16'h1004, 16'h0008, 0, 1);
        check("release_pcEn", 0, 16'(o_pcEn[0]), 16'h1);
        step(0, 16'hC040, 16'h000A, 0, 1);
        check("release_latch", 0, o_inst[0], 16'h1004);

        // JMP
        step(0, 16'h2000, 16'h000C, 0, 1);
        check("jmp_sel", 0, 16'(o_bs[0]), 16'h1);
        check("jmp_val", 0, 16'(o_bv[0]), 16'h0040);
        step(0, 16'h3000, 16'h0040, 0, 1);
        check("jmp_squash", 0, 16'(o_vld[0]), 16'h0);
        check("jmp_sel_off", 0, 16'(o_bs[0]), 16'h0);
        step(0, 16'h3001, 16'h0042, 0, 1);
        check("jmp_target", 0, o_pc[0], 16'h0040);
        step(0, 16'h3002, 16'h0044, 0, 1);
        step(0, 16'h3003, 16'h0046, 0, 1);

        // Back-to-back branches: C060 must never fire
        step(0, 16'hC050, 16'h0048, 0, 1);
        step(0, 16'hC060, 16'h004A, 0, 1);
        check("b2b_val", 0, 16'(o_bv[0]), 16'h0050);
        step(0, 16'h3100, 16'h0050, 0, 1);
        step(0, 16'h3101, 16'h0052, 0, 1);
        check("b2b_pc", 0, o_pc[0], 16'h0050);
        check("b2b_nofire", 0, 16'(o_bs[0]), 16'h0);
        step(0, 16'h3102, 16'h0054, 0, 1);
        step(0, 16'h3103, 16'h0056, 0, 1);
        step(0, 16'h3104, 16'h0058, 0, 1);

        // Branch held under stall
        step(0, 16'hC070, 16'h005A, 0, 1);
        step(0, 16'h4000, 16'h005C, 1, 0);
        check("hold_sel", 0, 16'(o_bs[0]), 16'h0);
        check("hold_pcEn", 0, 16'(o_pcEn[0]), 16'h0);
        step(0, 16'h4000, 16'h005C, 0, 1);
        check("hold_fire", 0, 16'(o_bv[0]), 16'h0070);
        step(0, 16'h5000, 16'h0070, 0, 1);
        step(0, 16'h5001, 16'h0072, 0, 1);
        check("hold_target", 0, o_pc[0], 16'h0070);
        step(0, 16'h5002, 16'h0074, 0, 1);
        step(0, 16'h5003, 16'h0076, 0, 1);
        step(0, 16'h5004, 16'h0078, 0, 1);

        // BEQZ with zeroFlag=0, then zeroFlag=1
        step(0, 16'hD020, 16'h007A, 0, 1);
        step(0, 16'h6000, 16'h007C, 0, 1);
        check("beqz_z0_sel", 0, 16'(o_bs[0]), 16'h0);
        step(0, 16'h6001, 16'h007E, 0, 1);
        check("beqz_z0_next", 0, o_inst[0], 16'h6000);
        step(0, 16'h6002, 16'h0080, 0, 1);
        step(0, 16'hD020, 16'h0082, 0, 1);
        step(0, 16'h6100, 16'h0084, 1, 1);
        check("beqz_z1_sel", 0, 16'(o_bs[0]), 16'(COND));
        check("beqz_z1_val", 0, 16'(o_bv[0]), COND ? 16'h0020 : 16'h0000);
        step(0, 16'h6101, 16'h0086, 0, 1);
        check("beqz_z1_vld", 0, 16'(o_vld[0]), 16'(!COND));
        step(0, 16'h6102, 16'h0088, 0, 1);
        step(0, 16'h6103, 16'h008A, 0, 1);
        step(0, 16'h6104, 16'h008C, 0, 1);
        // zeroFlag high only while stalled; low on the fire cycle
        step(0, 16'hD020, 16'h008E, 0, 1);
        step(0, 16'h7000, 16'h0090, 1, 0);
        step(0, 16'h7000, 16'h0090, 0, 1);
        check("beqz_late_zf", 0, 16'(o_bs[0]), 16'h0);
        step(0, 16'h7001, 16'h0092, 0, 1);
        step(0, 16'h7002, 16'h0094, 0, 1);
        step(0, 16'h7003, 16'h0096, 0, 1);

        // FLUSH_CYCLES=3: JMP then three dead cycles
        step(0, 16'hC040, 16'h0098, 0, 1);
        step(0, 16'h8000, 16'h009A, 0, 1);
        check("f3_fire", 1, 16'(o_bv[1]), 16'h0040);
        step(0, 16'h8001, 16'h0040, 0, 1);
        check("f3_dead1", 1, 16'(o_vld[1]), 16'h0);
        step(0, 16'h8002, 16'h0042, 0, 1);
        check("f3_dead2", 1, 16'(o_vld[1]), 16'h0);
        step(0, 16'h8003, 16'h0044, 0, 1);
        check("f3_dead3", 1, 16'(o_vld[1]), 16'h0);
        step(0, 16'h8004, 16'h0046, 0, 1);
        check("f3_capture_v", 1, 16'(o_vld[1]), 16'h1);
        check("f3_capture_pc", 1, o_pc[1], 16'h0044);

        // Reset in the second flush cycle
        step(0, 16'hC040, 16'h0048, 0, 1);
        step(0, 16'h8100, 16'h004A, 0, 1);
        step(0, 16'h8101, 16'h0040, 0, 1);
        step(1, 16'h8102, 16'h0042, 0, 1);
        check("f3_rst_pcEn", 1, 16'(o_pcEn[1]), 16'h0);
        step(0, 16'h8103, 16'h0044, 0, 1);
        check("f3_after_rst_v", 1, 16'(o_vld[1]), 16'h0);
        check("f3_after_rst_en", 1, 16'(o_pcEn[1]), 16'h1);
        step(0, 16'h8104, 16'h0046, 0, 1);
        check("f3_after_rst_inst", 1, o_inst[1], 16'h8103);

        // Reset during a stall
        step(0, 16'h9000, 16'h0050, 0, 1);
        step(0, 16'h9001, 16'h0052, 0, 0);
        check("stall_pre_rst", 0, 16'(o_pcEn[0]), 16'h0);
        step(1, 16'h9001, 16'h0052, 0, 0);
        step(0, 16'h9002, 16'h0054, 0, 0);
        check("stall_rst_en", 0, 16'(o_pcEn[0]), 16'h1);
        check("stall_rst_v", 0, 16'(o_vld[0]), 16'h0);
        step(0, 16'h9003, 16'h0056, 0, 1);
        check("stall_rst_inst", 0, o_inst[0], 16'h9002);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
